// File: rtl/sg_window_scheduler_if.sv
// rtl/sg_window_scheduler_if.sv - sample read, window/fit handshake and result write bundle
interface sg_window_scheduler_if #(
  parameter int WINDOW_SIZE = 7,
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 10
);
  logic                          rd_en;
  logic [ADDR_W-1:0]             rd_addr;
  logic [DATA_W-1:0]             rd_data;
  logic                          win_valid;
  logic                          win_ready;
  logic [WINDOW_SIZE*DATA_W-1:0] win_data;
  logic                          fit_valid;
  logic [DATA_W-1:0]             fit_data;
  logic                          wr_en;
  logic [ADDR_W-1:0]             wr_addr;
  logic [DATA_W-1:0]             wr_data;

  modport master (
    output rd_en, rd_addr, win_valid, win_data, wr_en, wr_addr, wr_data,
    input  rd_data, win_ready, fit_valid, fit_data
  );

  modport slave (
    input  rd_en, rd_addr, win_valid, win_data, wr_en, wr_addr, wr_data,
    output rd_data, win_ready, fit_valid, fit_data
  );
endinterface

// File: rtl/sg_window_scheduler.sv
// rtl/sg_window_scheduler.sv - sliding-window sequencer for the Savitzky-Golay smoothing pass
module sg_window_scheduler #(
  parameter int WINDOW_SIZE = 7,
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [ADDR_W:0]       len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  sg_window_scheduler_if.master bus
);
  localparam int HALF = WINDOW_SIZE / 2;
  localparam int CW   = ADDR_W + 1;
  localparam logic [CW-1:0] HALF_C = CW'(HALF);
  localparam logic [CW-1:0] WIN_C  = CW'(WINDOW_SIZE);
  localparam logic [CW-1:0] ONE_C  = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_ISSUE, S_WAIT_FIT, S_WRITE, S_SHIFT, S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     c_q, c_d;
  logic [CW-1:0]     len_q, len_d;
  logic [CW-1:0]     fill_q, fill_d;
  logic [CW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     wr_end_q, wr_end_d;
  logic [DATA_W-1:0] fit_q, fit_d;
  logic              err_q, err_d;
  logic              rd_pend_q;
  logic [DATA_W-1:0] win_q [WINDOW_SIZE];

  logic              rd_en_w;
  logic [ADDR_W-1:0] rd_addr_w;
  logic              win_valid_w;
  logic              wr_en_w;
  logic              first_win;
  logic              last_win;

  // First window pads the low edge, last window pads the high edge.
  assign first_win = (c_q == HALF_C);
  assign last_win  = (c_q == (len_q - HALF_C - ONE_C));

  // Control and datapath registers; a mid-pass reset drops everything back to IDLE.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      c_q       <= '0;
      len_q     <= '0;
      fill_q    <= '0;
      wr_ptr_q  <= '0;
      wr_end_q  <= '0;
      fit_q     <= '0;
      err_q     <= 1'b0;
      rd_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      c_q       <= c_d;
      len_q     <= len_d;
      fill_q    <= fill_d;
      wr_ptr_q  <= wr_ptr_d;
      wr_end_q  <= wr_end_d;
      fit_q     <= fit_d;
      err_q     <= err_d;
      rd_pend_q <= rd_en_w;
    end
  end

  // Window shift register: read data lands one cycle after the strobe, newest at the top slice.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < WINDOW_SIZE; k++) win_q[k] <= '0;
    end else if (rd_pend_q) begin
      for (int k = 0; k < WINDOW_SIZE - 1; k++) win_q[k] <= win_q[k+1];
      win_q[WINDOW_SIZE-1] <= bus.rd_data;
    end
  end

  // Next-state and output decode for the pass sequencer.
  always_comb begin
    state_d     = state_q;
    c_d         = c_q;
    len_d       = len_q;
    fill_d      = fill_q;
    wr_ptr_d    = wr_ptr_q;
    wr_end_d    = wr_end_q;
    fit_d       = fit_q;
    err_d       = err_q;
    rd_en_w     = 1'b0;
    rd_addr_w   = '0;
    win_valid_w = 1'b0;
    wr_en_w     = 1'b0;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          len_d = len_i;
          if (len_i >= WIN_C) begin
            state_d = S_FILL;
            c_d     = HALF_C;
            fill_d  = '0;
            err_d   = 1'b0;
          end else begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end
        end
      end
      S_FILL: begin
        busy_o = 1'b1;
        if (fill_q != WIN_C) begin
          rd_en_w   = 1'b1;
          rd_addr_w = ADDR_W'(fill_q);
          fill_d    = fill_q + ONE_C;
        end else if (rd_pend_q) begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        busy_o      = 1'b1;
        win_valid_w = 1'b1;
        if (bus.win_ready) state_d = S_WAIT_FIT;
      end
      S_WAIT_FIT: begin
        busy_o = 1'b1;
        if (bus.fit_valid) begin
          fit_d    = bus.fit_data;
          wr_ptr_d = first_win ? '0 : c_q;
          wr_end_d = last_win ? (len_q - ONE_C) : c_q;
          state_d  = S_WRITE;
        end
      end
      S_WRITE: begin
        busy_o   = 1'b1;
        wr_en_w  = 1'b1;
        wr_ptr_d = wr_ptr_q + ONE_C;
        if (wr_ptr_q == wr_end_q) state_d = last_win ? S_DONE : S_SHIFT;
      end
      S_SHIFT: begin
        busy_o = 1'b1;
        if (!rd_pend_q) begin
          rd_en_w   = 1'b1;
          rd_addr_w = ADDR_W'(c_q + HALF_C + ONE_C);
          c_d       = c_q + ONE_C;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign err_o         = err_q;
  assign bus.rd_en     = rd_en_w;
  assign bus.rd_addr   = rd_addr_w;
  assign bus.win_valid = win_valid_w;
  assign bus.wr_en     = wr_en_w;
  assign bus.wr_addr   = wr_en_w ? ADDR_W'(wr_ptr_q) : '0;
  assign bus.wr_data   = wr_en_w ? fit_q : '0;

  for (genvar g = 0; g < WINDOW_SIZE; g++) begin : g_win
    assign bus.win_data[g*DATA_W +: DATA_W] = win_q[g];
  end
endmodule

// File: tb/tb_sg_window_scheduler.sv
// tb/tb_sg_window_scheduler.sv - directed bench for sg_window_scheduler
module tb_sg_window_scheduler;
  localparam int W    = 7;
  localparam int DW   = 32;
  localparam int AW   = 10;
  localparam int HALF = W / 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW:0]   len = '0;
  logic          busy, done, err;

  sg_window_scheduler_if #(.WINDOW_SIZE(W), .DATA_W(DW), .ADDR_W(AW)) bus ();

  sg_window_scheduler #(.WINDOW_SIZE(W), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
    .len_i   (len),
    .busy_o  (busy),
    .done_o  (done),
    .err_o   (err),
    .bus     (bus.master)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Sample memory, fit stub (centre sample returned ~3 cycles after handshake), injection hooks.
  logic signed [DW-1:0] smem [0:1023];
  logic signed [DW-1:0] omem [0:1023];
  logic          win_ready_tb = 1'b1;
  logic          stub_fv = 1'b0;
  logic          inj_fv = 1'b0;
  logic [DW-1:0] stub_fd = '0;
  logic [DW-1:0] inj_fd = '0;
  int            cd = 0;

  assign bus.win_ready = win_ready_tb;
  assign bus.fit_valid = stub_fv | inj_fv;
  assign bus.fit_data  = inj_fv ? inj_fd : stub_fd;

  always @(posedge clk) begin
    if (bus.rd_en) bus.rd_data <= smem[bus.rd_addr];
    stub_fv <= 1'b0;
    if (cd != 0) begin
      cd <= cd - 1;
      if (cd == 1) stub_fv <= 1'b1;
    end
    if (bus.win_valid && bus.win_ready) begin
      cd      <= 3;
      stub_fd <= bus.win_data[HALF*DW +: DW];
    end
  end

  // Mid-cycle monitor: event counters and captured result memory.
  int   cyc = 0, n_win = 0, n_wr = 0, n_rd = 0, n_done = 0, last_wr_cyc = 0, done_cyc = 0;
  int   start_cyc = 0;
  logic clr = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (clr) begin
      n_win = 0; n_wr = 0; n_rd = 0; n_done = 0;
      for (int i = 0; i < 1024; i++) omem[i] = 32'hDEADBEEF;
    end else begin
      if (bus.rd_en) n_rd++;
      if (bus.win_valid && bus.win_ready) n_win++;
      if (bus.wr_en) begin
        n_wr++;
        omem[bus.wr_addr] = bus.wr_data;
        last_wr_cyc = cyc;
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
    end
  end

  typedef struct {
    int len;
    int scale;
    int exp_win;
    bit exp_err;
    int exp_first;
    int exp_last;
  } vec_t;

  localparam int NV = 6;
  vec_t vecs [NV];

  task automatic load(input int scale);
    for (int i = 0; i < 1024; i++) smem[i] = DW'(scale * i);
  endtask

  task automatic pulse_start(input int l);
    @(posedge clk); #1; clr = 1'b1;
    @(posedge clk); #1; clr = 1'b0; len = (AW+1)'(l); start = 1'b1; start_cyc = cyc;
    @(posedge clk); #1; start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while (done !== 1'b1 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check({name, " done_seen"}, longint'(k < 3000), 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_zero(input string name);
    check({name, " busy"}, busy, 0);
    check({name, " done"}, done, 0);
    check({name, " err"}, err, 0);
    check({name, " strobes"}, {bus.rd_en, bus.win_valid, bus.wr_en}, 0);
    check({name, " addr_data"}, longint'((bus.rd_addr | bus.wr_addr) == 0 && bus.wr_data == 0), 1);
    check({name, " win_data"}, longint'(bus.win_data == '0), 1);
  endtask

  task automatic check_pass(input string name, input vec_t t);
    int bad = 0;
    int cc;
    check({name, " windows"}, n_win, t.exp_win);
    check({name, " done_pulses"}, n_done, 1);
    check({name, " err"}, err, t.exp_err);
    check({name, " busy_after"}, busy, 0);
    check({name, " reads"}, n_rd, t.exp_err ? 0 : t.len);
    check({name, " writes"}, n_wr, t.exp_err ? 0 : t.len);
    if (!t.exp_err) begin
      check({name, " out_first"}, int'(omem[0]), t.exp_first);
      check({name, " out_last"}, int'(omem[t.len-1]), t.exp_last);
      for (int n = 0; n < t.len; n++) begin
        cc = (n < HALF) ? HALF : ((n > t.len - HALF - 1) ? t.len - HALF - 1 : n);
        if (int'(omem[n]) != t.scale * cc) bad++;
      end
      check({name, " out_model_mismatches"}, bad, 0);
      check({name, " done_after_last_write"}, done_cyc - last_wr_cyc, 1);
    end else begin
      check({name, " done_latency_le2"}, longint'(done_cyc - start_cyc <= 2), 1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W*DW-1:0] wd, exp_wd;
    logic stable, quiet, saw;
    int   k, w0;

    vecs[0] = '{len: 30, scale: 1,  exp_win: 24, exp_err: 1'b0, exp_first: 3,  exp_last: 26};
    vecs[1] = '{len: 7,  scale: 10, exp_win: 1,  exp_err: 1'b0, exp_first: 30, exp_last: 30};
    vecs[2] = '{len: 8,  scale: 2,  exp_win: 2,  exp_err: 1'b0, exp_first: 6,  exp_last: 8};
    vecs[3] = '{len: 9,  scale: -3, exp_win: 3,  exp_err: 1'b0, exp_first: -9, exp_last: -15};
    vecs[4] = '{len: 0,  scale: 1,  exp_win: 0,  exp_err: 1'b1, exp_first: 0,  exp_last: 0};
    vecs[5] = '{len: 6,  scale: 1,  exp_win: 0,  exp_err: 1'b1, exp_first: 0,  exp_last: 0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1; rst = 1'b0;

    for (int v = 0; v < NV; v++) begin
      string nm;
      nm = $sformatf("vec%0d_len%0d", v, vecs[v].len);
      load(vecs[v].scale);
      pulse_start(vecs[v].len);
      check({nm, " busy_during"}, busy, !vecs[v].exp_err);
      wait_done(nm);
      check_pass(nm, vecs[v]);
    end

    // Reset while waiting for the fit result; the late fit_valid must not produce a write.
    load(1);
    pulse_start(30);
    k = 0;
    while (!(bus.win_valid === 1'b1 && bus.win_ready === 1'b1) && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("T5 handshake_reached", longint'(k < 200), 1);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check_zero("T5 after_reset");
    w0 = n_wr;
    saw = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus.fit_valid === 1'b1) saw = 1'b1;
    end
    check("T5 stale_fit_seen", saw, 1);
    check("T5 stale_writes", n_wr - w0, 0);
    check("T5 idle_busy", busy, 0);
    pulse_start(30);
    wait_done("T5 rerun");
    check_pass("T5 rerun", vecs[0]);

    // Back-pressure on the first window.
    load(1);
    win_ready_tb = 1'b0;
    pulse_start(30);
    k = 0;
    while (bus.win_valid !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("T4 issue_reached", longint'(k < 200), 1);
    wd = bus.win_data;
    for (int j = 0; j < W; j++) exp_wd[j*DW +: DW] = DW'(j);
    check("T4 first_window", longint'(wd == exp_wd), 1);
    stable = 1'b1;
    quiet  = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!(bus.win_valid === 1'b1 && bus.win_data === wd)) stable = 1'b0;
      if (bus.rd_en !== 1'b0 || bus.wr_en !== 1'b0) quiet = 1'b0;
    end
    check("T4 window_stable", stable, 1);
    check("T4 no_rd_wr", quiet, 1);
    @(posedge clk); #1; win_ready_tb = 1'b1;
    wait_done("T4");
    check_pass("T4", vecs[0]);

    // Stray start mid-pass and a fit_valid injected while a window is on offer.
    load(1);
    pulse_start(30);
    repeat (40) @(posedge clk);
    #1; start = 1'b1; len = (AW+1)'(6);
    @(posedge clk); #1; start = 1'b0; win_ready_tb = 1'b0;
    k = 0;
    while (bus.win_valid !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("T6 issue_reached", longint'(k < 200), 1);
    @(posedge clk); #1; inj_fv = 1'b1; inj_fd = 32'h0BAD0BAD;
    repeat (2) @(posedge clk);
    #1; inj_fv = 1'b0; win_ready_tb = 1'b1;
    check("T6 busy_kept", busy, 1);
    wait_done("T6");
    check_pass("T6", vecs[0]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
